// File: rtl/regfile_pkg.sv
// Shared widths, pattern step and BIST state encoding for the register file
// self-test and anything that needs to regenerate its pattern.
package regfile_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;

    localparam logic [7:0] PAT_STEP = 8'h11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Entry a holds seed + 0x11*a, truncated to the register width.
    function automatic logic [DATA_W-1:0] pattern(input logic [DATA_W-1:0] seed,
                                                  input logic [ADDR_W-1:0] addr);
        return seed + DATA_W'(PAT_STEP) * DATA_W'(addr);
    endfunction

endpackage

// File: rtl/regfile_bist.sv
// Self-test initiator for the 8x8 register file: writes a seeded pattern to
// every entry, reads it back two entries per cycle and reports the result.
//
// state | meaning
// IDLE  | rf pins released (write disabled, addr/data 0); results hold
// WRITE | one entry written per cycle, counter is the write address
// READ  | one address pair checked per cycle, counter is the pair index
// DONE  | one-cycle done pulse, pass/fail_count/fail_addr final
module regfile_bist #(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W,
    parameter int DEPTH  = regfile_pkg::DEPTH
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_seed,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_pass,
    output logic [ADDR_W:0]   o_fail_count,
    output logic [ADDR_W-1:0] o_fail_addr,
    output logic [ADDR_W-1:0] o_rf_write_addr,
    output logic [DATA_W-1:0] o_rf_write_data,
    output logic              o_rf_regwrite_n,
    output logic [ADDR_W-1:0] o_rf_read_addr_1,
    output logic [ADDR_W-1:0] o_rf_read_addr_2,
    input  logic [DATA_W-1:0] i_rf_read_data_1,
    input  logic [DATA_W-1:0] i_rf_read_data_2
);
    import regfile_pkg::*;

    localparam int              CNT_W  = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] W_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] R_LAST = ADDR_W'(DEPTH / 2 - 1);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_cnt;
    logic [DATA_W-1:0]   r_seed;

    logic [ADDR_W-1:0]   w_rd_addr_1;
    logic [ADDR_W-1:0]   w_rd_addr_2;
    logic [DATA_W-1:0]   w_exp_1;
    logic [DATA_W-1:0]   w_exp_2;
    logic [DATA_W-1:0]   w_wr_data;
    logic                w_miss_1;
    logic                w_miss_2;
    logic [ADDR_W:0]     w_fail_count_nxt;

    always_comb begin
        w_rd_addr_1      = {r_cnt[ADDR_W-2:0], 1'b0};
        w_rd_addr_2      = {r_cnt[ADDR_W-2:0], 1'b1};
        w_exp_1          = r_seed + DATA_W'(PAT_STEP) * DATA_W'(w_rd_addr_1);
        w_exp_2          = r_seed + DATA_W'(PAT_STEP) * DATA_W'(w_rd_addr_2);
        w_wr_data        = r_seed + DATA_W'(PAT_STEP) * DATA_W'(r_cnt);
        w_miss_1         = (r_state == READ) && (i_rf_read_data_1 != w_exp_1);
        w_miss_2         = (r_state == READ) && (i_rf_read_data_2 != w_exp_2);
        w_fail_count_nxt = o_fail_count + CNT_W'(w_miss_1) + CNT_W'(w_miss_2);

        // Pins stay parked outside the phase that owns them.
        o_rf_regwrite_n  = 1'b1;
        o_rf_write_addr  = '0;
        o_rf_write_data  = '0;
        o_rf_read_addr_1 = '0;
        o_rf_read_addr_2 = '0;
        case (r_state)
            WRITE: begin
                o_rf_regwrite_n = 1'b0;
                o_rf_write_addr = r_cnt;
                o_rf_write_data = w_wr_data;
            end
            READ: begin
                o_rf_read_addr_1 = w_rd_addr_1;
                o_rf_read_addr_2 = w_rd_addr_2;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_seed       <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_pass       <= 1'b0;
            o_fail_count <= '0;
            o_fail_addr  <= '0;
        end else begin
            o_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_seed       <= i_seed;
                        r_cnt        <= '0;
                        o_busy       <= 1'b1;
                        o_pass       <= 1'b0;
                        o_fail_count <= '0;
                        o_fail_addr  <= '0;
                        r_state      <= WRITE;
                    end
                end
                WRITE: begin
                    if (r_cnt == W_LAST) begin
                        r_cnt   <= '0;
                        r_state <= READ;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                READ: begin
                    o_fail_count <= w_fail_count_nxt;
                    // A zero count means no mismatch recorded yet; port 1 has the lower address.
                    if (o_fail_count == '0) begin
                        if (w_miss_1) begin
                            o_fail_addr <= w_rd_addr_1;
                        end else if (w_miss_2) begin
                            o_fail_addr <= w_rd_addr_2;
                        end
                    end
                    if (r_cnt == R_LAST) begin
                        r_cnt   <= '0;
                        o_busy  <= 1'b0;
                        o_done  <= 1'b1;
                        o_pass  <= (w_fail_count_nxt == '0);
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/regfile_bist.md
# regfile_bist

Built-in self-test initiator for the 8×8 register file (two asynchronous read ports, one clocked write port with active-low write enable). On `start`, it writes a seed-derived pattern into every entry, then reads the pattern back through both read ports in parallel. It reports pass/fail, the mismatch count and the lowest failing address. It sits between the board control logic and the register file's port pins, and drives those pins only while a test runs.

## Interface
- `DATA_W`, default 8: register width.
- `ADDR_W`, default 3: address width.
- `DEPTH`, default 8: number of entries; must equal 2**ADDR_W and be even.
- `clk`  in  1  single clock; also drives the register file's `clk`.
- `reset`  in  1  synchronous, active-high; does not drive the register file's own reset.
- `start`  in  1  begin a test; sampled only in IDLE.
- `seed`  in  DATA_W  pattern base; captured when `start` is accepted.
- `busy`  out  1  high in WRITE and READ.
- `done`  out  1  one-cycle pulse in DONE.
- `pass`  out  1  result of last test; valid from `done` until next accepted `start`.
- `fail_count`  out  ADDR_W+1  number of mismatching entries (0..DEPTH).
- `fail_addr`  out  ADDR_W  lowest mismatching address; 0 when `fail_count`=0.
- `rf_write_addr`  out  ADDR_W  register file write address.
- `rf_write_data`  out  DATA_W  register file write data.
- `rf_regwrite_n`  out  1  active-low write enable.
- `rf_read_addr_1`, `rf_read_addr_2`  out  ADDR_W  read addresses.
- `rf_read_data_1`, `rf_read_data_2`  in  DATA_W  combinational read data.

## Operation
- Pattern: P(a) = (seed_q + 8'h11·a) mod 2**DATA_W. This is DATA_W-bit truncating addition with no saturation.
- States and transitions:
  - IDLE → WRITE on `start`=1.
  - WRITE → READ after entry DEPTH-1 is written.
  - READ → DONE after pair DEPTH/2-1 is checked.
  - DONE → IDLE unconditionally.
- IDLE: `rf_regwrite_n`=1; address and data outputs are 0; result outputs hold their last values.
- On accepting `start`: capture `seed_q`; clear `pass`, `fail_count` and `fail_addr`.
- WRITE: write counter `w` runs 0..DEPTH-1, one entry per cycle. Drive `rf_write_addr`=w, `rf_write_data`=P(w), `rf_regwrite_n`=0.
- READ: pair counter `r` runs 0..DEPTH/2-1. Drive `rf_read_addr_1`=2r and `rf_read_addr_2`=2r+1, with `rf_regwrite_n`=1.
- READ compare: compare both read ports in the same cycle, combinationally, against P(2r) and P(2r+1).
  - Add 0, 1 or 2 to `fail_count` for that pair.
  - `fail_addr` takes the first mismatch only, in ascending address order; port 1 is checked before port 2.
- DONE: assert `done`; set `pass`=(`fail_count`==0); `busy`=0.
- `start` while busy or in DONE is ignored; it is not queued. If `start` is held high continuously, a new test begins on the cycle after DONE (the IDLE cycle).
- Synchronous `reset` at any point:
  - next state IDLE;
  - `rf_regwrite_n`=1;
  - `busy`, `done`, `pass`, `fail_count` and `fail_addr` all 0;
  - counters 0.
  - A test interrupted mid-WRITE leaves the register file partially written; this is acceptable.

## Timing
- Let edge 0 be the edge where `start` is sampled in IDLE.
- WRITE occupies cycles 1..DEPTH. Each write commits at the end of its cycle.
- READ occupies cycles DEPTH+1..DEPTH+DEPTH/2. Data written in the final WRITE cycle is visible from the first READ cycle.
- `done` is high in cycle DEPTH+DEPTH/2+1 (cycle 13 for defaults). `pass` is valid in that same cycle.
- `busy` is high in exactly cycles 1..12 for defaults.
- All outputs are registered except `rf_*` address/data, which decode from state and counters.

## Structure
- Shared package `regfile_pkg`: `DATA_W`, `ADDR_W`, `DEPTH`, pattern step constant 8'h11, and the state enum {IDLE, WRITE, READ, DONE}.
- The block is a single module; no sub-module is warranted. The pattern function lives in the package so the bench reuses it.
- Integration: instantiate the block alongside the register file, muxing its `rf_*` outputs with switch/key control under `busy`.

## Test plan
- Seed 8'h00 with a healthy register file model:
  - writes 00,11,22,…,77 to addresses 0..7;
  - `done` pulses at cycle 13;
  - `pass`=1, `fail_count`=0, `fail_addr`=0.
- Seed 8'hF0 (wrap-around) → entries F0,01,12,23,34,45,56,67; `pass`=1.
- Seed 8'h00 with the model's address 5 bit 0 stuck-at-0, so 8'h55 reads as 8'h54 → `pass`=0, `fail_count`=1, `fail_addr`=5.
- Faults at addresses 2 and 3 (same pair) and at 6 → `fail_count`=3, `fail_addr`=2.
- `reset` asserted in cycle 4 of WRITE → next cycle `rf_regwrite_n`=1, `busy`=0, state IDLE, and no `done` pulse. A following `start` completes normally in 13 cycles.
- `start` pulsed again in cycle 6 → ignored, with a single `done` at cycle 13. With `start` held high, a second `done` appears at cycle 27.
